// File: rtl/fetch_unit_pkg.sv
// Shared types for the rv32i instruction-fetch front end.
package fetch_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, KILL} fetch_state_e;

  function automatic rv32i_word word_align(input rv32i_word a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// icache port plus IF/ID handshake; master is the fetch unit, slave is cache/consumer side.
interface fetch_unit_if;
  import fetch_types::*;

  logic      icache_read;
  logic      icache_write;
  logic [3:0] icache_byte_enable;
  rv32i_word icache_addr;
  rv32i_word icache_wdata;
  rv32i_word icache_rdata;
  logic      icache_resp;
  logic      redirect;
  rv32i_word redirect_pc;
  logic      out_valid;
  logic      out_ready;
  rv32i_word out_pc;
  rv32i_word out_instr;

  modport master (
    output icache_read, icache_write, icache_byte_enable, icache_addr, icache_wdata,
    input  icache_rdata, icache_resp,
    input  redirect, redirect_pc,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  icache_read, icache_write, icache_byte_enable, icache_addr, icache_wdata,
    output icache_rdata, icache_resp,
    output redirect, redirect_pc,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Registered FIFO of fetched {pc, instr} pairs; flush wins over push/pop.
module fetch_queue
  import fetch_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o
);

  fetch_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  // AW-bit pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: one outstanding icache read, queued results, redirect flush/kill.
module fetch_unit
  import fetch_types::*;
#(
  parameter int        DEPTH    = 4,
  parameter rv32i_word RESET_PC = 32'h0000_0060
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q;
  rv32i_word     fetch_pc_q;
  rv32i_word     kill_addr_q;
  logic          read_q;

  fetch_entry_t  push_entry, head;
  logic [CW-1:0] count, count_after_push;
  logic          empty, push, pop;

  assign push       = (state_q == REQ) && bus.icache_resp && !bus.redirect;
  assign pop        = !empty && bus.out_ready && !bus.redirect;
  assign push_entry = '{pc: fetch_pc_q, instr: bus.icache_rdata};
  assign count_after_push = count + CW'(1) - CW'(pop);

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

  // Requests are only issued with a free slot reserved, so push never overflows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= '0;
      read_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc_q <= word_align(bus.redirect_pc);
            state_q    <= REQ;
            read_q     <= 1'b1;
          end else if (count < CW'(DEPTH)) begin
            state_q <= REQ;
            read_q  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc_q <= word_align(bus.redirect_pc);
            if (!bus.icache_resp) begin
              // old read must still complete at its address; its data is dropped
              kill_addr_q <= fetch_pc_q;
              state_q     <= KILL;
            end
          end else if (bus.icache_resp) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (count_after_push >= CW'(DEPTH)) begin
              state_q <= IDLE;
              read_q  <= 1'b0;
            end
          end
        end
        KILL: begin
          if (bus.redirect) fetch_pc_q <= word_align(bus.redirect_pc);
          if (bus.icache_resp) state_q <= REQ;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.icache_read        = read_q;
  assign bus.icache_write       = 1'b0;
  assign bus.icache_byte_enable = 4'hF;
  assign bus.icache_wdata       = '0;
  assign bus.icache_addr        = (state_q == KILL) ? kill_addr_q : word_align(fetch_pc_q);
  assign bus.out_valid          = !empty;
  assign bus.out_pc             = head.pc;
  assign bus.out_instr          = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cache model, scoreboard of expected output PCs, redirect table.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if ic();

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0060)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ic.master)
  );

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int ccnt     = 0;
  bit cache_en = 1'b1;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } rd_vec_t;
  rd_vec_t vecs[4];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // icache model: responds after 'lat' waiting cycles, resp is a one-cycle pulse
  always @(negedge clk) begin
    if (!rst) begin
      ic.icache_resp = 1'b0;
      ccnt = 0;
    end else if (cache_en) begin
      if (ic.icache_resp) begin
        ic.icache_resp = 1'b0;
        ccnt = 0;
      end
      if (ic.icache_read) begin
        if (ccnt >= lat) begin
          ic.icache_resp  = 1'b1;
          ic.icache_rdata = instr_of(ic.icache_addr);
        end else ccnt++;
      end
    end
  end

  // consumer monitor: every accepted head is compared with the scoreboard front
  always begin
    @(negedge clk);
    #3;
    if (rst && ic.out_valid && ic.out_ready && sb.size() > 0) begin
      logic [31:0] e;
      e = sb.pop_front();
      chk("pop_pc", ic.out_pc, e);
      chk("pop_instr", ic.out_instr, instr_of(e));
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    #2;
    rst = 1'b0;
    cache_en = 1'b1;
    ic.icache_resp = 1'b0;
    ic.redirect = 1'b0;
    ic.out_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic wait_addr(input string nm, input logic [31:0] a, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ic.icache_read && ic.icache_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string nm, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};

    ic.icache_resp = 1'b0;
    ic.icache_rdata = '0;
    ic.redirect = 1'b0;
    ic.redirect_pc = '0;
    ic.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_read", 32'(ic.icache_read), 0);
    chk("rst_valid", 32'(ic.out_valid), 0);
    chk("rst_pc", ic.out_pc, 0);
    chk("rst_instr", ic.out_instr, 0);
    chk("rst_write", 32'(ic.icache_write), 0);
    chk("rst_be", 32'(ic.icache_byte_enable), 32'hF);

    // sequential fetch, one-cycle responses, consumer always ready
    reset_dut();
    lat = 0;
    ic.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(32'h60 + 32'(4 * i));
    @(negedge clk);
    chk("t1_read", 32'(ic.icache_read), 1);
    chk("t1_addr0", ic.icache_addr, 32'h60);
    chk("t1_valid_before", 32'(ic.out_valid), 0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("t1_addr", ic.icache_addr, 32'h60 + 32'(4 * i));
      if (i == 1) chk("t1_valid_after", 32'(ic.out_valid), 1);
    end
    drain("t1_drain", 40);

    // consumer stalled: exactly DEPTH requests, then fetch resumes after pops
    reset_dut();
    lat = 0;
    begin
      int nreq = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (ic.icache_read) begin
          chk("t2_addr", ic.icache_addr, 32'h60 + 32'(4 * nreq));
          nreq++;
        end
      end
      chk("t2_nreq", 32'(nreq), 4);
      chk("t2_idle", 32'(ic.icache_read), 0);
      chk("t2_full_valid", 32'(ic.out_valid), 1);
    end
    for (int i = 0; i < 5; i++) sb.push_back(32'h60 + 32'(4 * i));
    ic.out_ready = 1'b1;
    wait_addr("t2_resume_0x70", 32'h70, 20);
    drain("t2_drain", 40);

    // redirect while a request is waiting: old address held, its data discarded
    foreach (vecs[v]) begin
      reset_dut();
      lat = 3;
      ic.out_ready = 1'b1;
      sb.push_back(32'h60);
      sb.push_back(vecs[v].exp_addr);
      sb.push_back(vecs[v].exp_next);
      wait_addr("tv_wait_0x64", 32'h64, 40);
      @(negedge clk);
      ic.redirect = 1'b1;
      ic.redirect_pc = vecs[v].rpc;
      @(negedge clk);
      ic.redirect = 1'b0;
      begin
        int held = 0;
        for (int i = 0; i < 20; i++) begin
          if (!(ic.icache_read && ic.icache_addr == 32'h64)) break;
          held++;
          @(negedge clk);
        end
        chk("tv_held_kill", 32'(held >= 2), 1);
      end
      chk("tv_read_after_kill", 32'(ic.icache_read), 1);
      chk("tv_target_addr", ic.icache_addr, vecs[v].exp_addr);
      drain("tv_drain", 60);
    end

    // redirect in the same cycle as the response for 0x68
    reset_dut();
    lat = 0;
    wait_addr("t4_wait_0x68", 32'h68, 20);
    ic.redirect = 1'b1;
    ic.redirect_pc = 32'h103;
    @(negedge clk);
    ic.redirect = 1'b0;
    chk("t4_flushed", 32'(ic.out_valid), 0);
    chk("t4_read", 32'(ic.icache_read), 1);
    chk("t4_addr", ic.icache_addr, 32'h100);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    ic.out_ready = 1'b1;
    drain("t4_drain", 40);

    // back-to-back redirects: the last target wins
    reset_dut();
    lat = 3;
    ic.out_ready = 1'b1;
    sb.push_back(32'h60);
    sb.push_back(32'h400);
    sb.push_back(32'h404);
    wait_addr("t5_wait_0x64", 32'h64, 40);
    @(negedge clk);
    ic.redirect = 1'b1;
    ic.redirect_pc = 32'h300;
    @(negedge clk);
    ic.redirect_pc = 32'h400;
    @(negedge clk);
    ic.redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!(ic.icache_read && ic.icache_addr == 32'h64)) break;
      @(negedge clk);
    end
    chk("t5_addr", ic.icache_addr, 32'h400);
    drain("t5_drain", 60);

    // reset mid-request with two entries queued; stale resp after release ignored
    reset_dut();
    lat = 2;
    wait_addr("t6_wait_0x68", 32'h68, 40);
    chk("t6_valid_pre", 32'(ic.out_valid), 1);
    #2;
    cache_en = 1'b0;
    rst = 1'b0;
    ic.icache_resp = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(ic.out_valid), 0);
    chk("t6_read_rst", 32'(ic.icache_read), 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    ic.icache_resp = 1'b1;
    ic.icache_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    ic.icache_resp = 1'b0;
    @(negedge clk);
    chk("t6_read_post", 32'(ic.icache_read), 1);
    chk("t6_addr_post", ic.icache_addr, 32'h60);
    chk("t6_valid_post", 32'(ic.out_valid), 0);
    cache_en = 1'b1;
    sb.push_back(32'h60);
    sb.push_back(32'h64);
    ic.out_ready = 1'b1;
    drain("t6_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
